// File: rtl/pack_framer.sv
// Transmit framer: prepends a fixed soft-symbol preamble to each upstream packet,
// caps the payload length and enforces a minimum idle gap between packets.
module pack_framer #(
  parameter int                    cPREA_LEN = 128,
  parameter int                    cGAP_LEN  = 4,
  parameter int                    cMAX_LEN  = 1024,
  parameter logic [4:0]            cSYM_ONE  = 5'h0F,
  parameter logic [4:0]            cSYM_ZERO = 5'h11,
  parameter logic [cPREA_LEN-1:0]  preambule = 128'hA5C3_0F96_E17B_2D48_9C3E_F012_6BD7_485A
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic [4:0] idat,
  input  logic       ival,
  input  logic       isop,
  input  logic       ieop,
  output logic       ordy,
  input  logic       iready,
  output logic [4:0] odat,
  output logic       oval,
  output logic       osop,
  output logic       oeop,
  output logic       oerr,
  output logic [2:0] dbg_state
);

  localparam int IW = $clog2(cPREA_LEN);
  localparam int CW = $clog2(cMAX_LEN + 1);
  localparam int GW = $clog2(cGAP_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_PAYLOAD  = 3'd2,
    S_DROP     = 3'd3,
    S_GAP      = 3'd4
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap_cnt;

  logic       advance;
  logic       last_sym;
  logic [4:0] pre_sym;

  // Handshake: an input symbol moves when ival & ordy; an output symbol moves
  // when oval & iready. The output register may load only when it is empty
  // or being emptied this cycle (advance).
  assign advance   = ~oval | iready;
  assign last_sym  = (cnt == CW'(cMAX_LEN - 1));
  assign pre_sym   = preambule[idx] ? cSYM_ONE : cSYM_ZERO;
  assign dbg_state = state;

  always_comb begin
    ordy = 1'b0;
    if (!irst) begin
      case (state)
        S_IDLE:    ordy = ival & ~isop;
        S_PAYLOAD: ordy = advance;
        S_DROP:    ordy = 1'b1;
        default:   ordy = 1'b0;
      endcase
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state   <= S_IDLE;
      idx     <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
      odat    <= '0;
      oval    <= 1'b0;
      osop    <= 1'b0;
      oeop    <= 1'b0;
      oerr    <= 1'b0;
    end else begin
      oerr <= 1'b0;
      case (state)
        S_IDLE: begin
          // A start symbol is left at the input; PAYLOAD consumes it later.
          if (ival) begin
            if (isop) begin
              state <= S_PREAMBLE;
              idx   <= '0;
            end else begin
              oerr <= 1'b1;
            end
          end
        end

        S_PREAMBLE: begin
          if (advance) begin
            odat <= pre_sym;
            oval <= 1'b1;
            osop <= (idx == '0);
            oeop <= 1'b0;
            if (idx == IW'(cPREA_LEN - 1)) begin
              state <= S_PAYLOAD;
              cnt   <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end

        S_PAYLOAD: begin
          if (advance) begin
            osop <= 1'b0;
            if (ival) begin
              odat <= idat;
              oval <= 1'b1;
              oeop <= ieop | last_sym;
              if (cnt != CW'(cMAX_LEN)) cnt <= cnt + CW'(1);
              if (ieop) begin
                state   <= S_GAP;
                gap_cnt <= '0;
              end else if (last_sym) begin
                state <= S_DROP;
                oerr  <= 1'b1;
              end
            end else begin
              oval <= 1'b0;
              oeop <= 1'b0;
            end
          end
        end

        S_DROP: begin
          // The truncated last symbol may still be waiting downstream.
          if (advance) begin
            oval <= 1'b0;
            osop <= 1'b0;
            oeop <= 1'b0;
          end
          if (ival && ieop) begin
            state   <= S_GAP;
            gap_cnt <= '0;
          end
        end

        S_GAP: begin
          if (oval) begin
            if (iready) begin
              oval    <= 1'b0;
              osop    <= 1'b0;
              oeop    <= 1'b0;
              gap_cnt <= '0;
            end
          end else if (gap_cnt >= GW'(cGAP_LEN - 1)) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pack_framer.sv
// Bench for pack_framer: directed steps with random payloads, bubbles and
// backpressure, checked against a frame-level model of the expected stream.
module tb_pack_framer;

  localparam int           PREA  = 128;
  localparam int           GAPN  = 4;
  localparam int           MAX_A = 1024;
  localparam int           MAX_B = 8;
  localparam logic [4:0]   SYM1  = 5'h0F;
  localparam logic [4:0]   SYM0  = 5'h11;
  localparam logic [127:0] PRE   = 128'h3C5A_9F01_77E2_B4D8_0A6C_E935_1F8B_C247;

  logic       iclk   = 1'b0;
  logic       irst   = 1'b1;
  logic [4:0] idat   = '0;
  logic       ival   = 1'b0;
  logic       isop   = 1'b0;
  logic       ieop   = 1'b0;
  logic       iready = 1'b1;
  logic       sel    = 1'b0;

  logic       ival_a, ival_b;
  logic       a_ordy, a_oval, a_osop, a_oeop, a_oerr;
  logic [4:0] a_odat;
  logic [2:0] a_state;
  logic       b_ordy, b_oval, b_osop, b_oeop, b_oerr;
  logic [4:0] b_odat;
  logic [2:0] b_state;

  logic       o_ordy, o_oval, o_osop, o_oeop, o_oerr;
  logic [4:0] o_odat;

  assign ival_a = ival & ~sel;
  assign ival_b = ival & sel;
  assign o_ordy = sel ? b_ordy : a_ordy;
  assign o_oval = sel ? b_oval : a_oval;
  assign o_osop = sel ? b_osop : a_osop;
  assign o_oeop = sel ? b_oeop : a_oeop;
  assign o_oerr = sel ? b_oerr : a_oerr;
  assign o_odat = sel ? b_odat : a_odat;

  pack_framer #(.cPREA_LEN(PREA), .cGAP_LEN(GAPN), .cMAX_LEN(MAX_A),
                .cSYM_ONE(SYM1), .cSYM_ZERO(SYM0), .preambule(PRE)) dut (
    .iclk(iclk), .irst(irst), .idat(idat), .ival(ival_a), .isop(isop), .ieop(ieop),
    .ordy(a_ordy), .iready(iready), .odat(a_odat), .oval(a_oval), .osop(a_osop),
    .oeop(a_oeop), .oerr(a_oerr), .dbg_state(a_state)
  );

  pack_framer #(.cPREA_LEN(PREA), .cGAP_LEN(GAPN), .cMAX_LEN(MAX_B),
                .cSYM_ONE(SYM1), .cSYM_ZERO(SYM0), .preambule(PRE)) dut_short (
    .iclk(iclk), .irst(irst), .idat(idat), .ival(ival_b), .isop(isop), .ieop(ieop),
    .ordy(b_ordy), .iready(iready), .odat(b_odat), .oval(b_oval), .osop(b_osop),
    .oeop(b_oeop), .oerr(b_oerr), .dbg_state(b_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 iclk = ~iclk;

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  int start_cyc = -1;
  int sop_cyc = -1;
  int err_pulses = 0;

  logic [6:0] exp_q[$];
  logic [6:0] act_q[$];
  logic [4:0] pay[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- downstream ready generator ----------------
  initial forever begin
    @(posedge iclk);
    #1;
    case (rdy_mode)
      0:       iready = 1'b1;
      1:       iready = ~iready;
      default: iready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // ---------------- output monitor ----------------
  logic       prev_hold = 1'b0;
  logic       prev_rst  = 1'b1;
  logic [7:0] prev_out  = '0;
  logic       after_eop = 1'b0;
  int         idle_run  = 0;

  initial forever begin
    @(negedge iclk);
    if (!irst && !prev_rst && prev_hold)
      check("hold", {24'd0, o_oval, o_osop, o_oeop, o_odat}, {24'd0, prev_out});
    if (irst) begin
      after_eop = 1'b0;
    end else begin
      if (o_oerr) err_pulses++;
      if (o_oval && o_osop && !prev_hold) sop_cyc = cyc;
      if (after_eop) begin
        if (o_oval) begin
          check("gap_idle", 32'(idle_run >= GAPN), 32'd1);
          after_eop = 1'b0;
        end else begin
          idle_run++;
        end
      end
      if (o_oval && iready) begin
        act_q.push_back({o_osop, o_oeop, o_odat});
        if (o_oeop) begin
          after_eop = 1'b1;
          idle_run  = 0;
        end
      end
    end
    prev_hold = o_oval && !iready && !irst;
    prev_out  = {o_oval, o_osop, o_oeop, o_odat};
    prev_rst  = irst;
  end

  // ---------------- model and driver tasks ----------------
  task automatic gen_ramp(input int n);
    pay.delete();
    for (int j = 0; j < n; j++) pay.push_back(5'(j));
  endtask

  task automatic gen_rand(input int n);
    pay.delete();
    for (int j = 0; j < n; j++) pay.push_back(5'($urandom));
  endtask

  // Expected accepted stream: every preamble bit as a soft symbol, then the
  // payload cut to maxlen symbols, with the last emitted symbol flagged eop.
  task automatic expect_frame(input int n, input int maxlen);
    logic [PREA-1:0] pre_v;
    int k;
    pre_v = PRE;
    k = (n < maxlen) ? n : maxlen;
    for (int i = 0; i < PREA; i++)
      exp_q.push_back({(i == 0), 1'b0, (pre_v[i] ? SYM1 : SYM0)});
    for (int j = 0; j < k; j++)
      exp_q.push_back({1'b0, (j == k - 1), pay[j]});
  endtask

  task automatic send_pkt(input int n, input bit bubbles, input int mid_sop);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 5000) begin
      @(posedge iclk);
      #1;
      guard++;
      ival = !(bubbles && i != 0 && $urandom_range(0, 3) == 0);
      idat = pay[i];
      isop = (i == 0) || (i == mid_sop);
      ieop = (i == n - 1);
      if (i == 0 && start_cyc < 0) start_cyc = cyc;
      @(negedge iclk);
      if (ival && o_ordy) i++;
    end
    check("send_done", 32'(i), 32'(n));
  endtask

  task automatic idle_in();
    @(posedge iclk);
    #1;
    ival = 1'b0;
    isop = 1'b0;
    ieop = 1'b0;
  endtask

  task automatic drain_compare(input string tag);
    int guard = 0;
    while (act_q.size() < exp_q.size() && guard < 5000) begin
      @(negedge iclk);
      guard++;
    end
    repeat (12) @(negedge iclk);
    check({tag, "_len"}, 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), {25'd0, act_q[i]}, {25'd0, exp_q[i]});
    act_q.delete();
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e0;
    int n;
    int guard;

    // reset state
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    check("rst_oval", 32'(o_oval), 32'd0);
    check("rst_osop", 32'(o_osop), 32'd0);
    check("rst_oeop", 32'(o_oeop), 32'd0);
    check("rst_oerr", 32'(o_oerr), 32'd0);
    check("rst_odat", 32'(o_odat), 32'd0);
    check("rst_ordy", 32'(o_ordy), 32'd0);
    @(posedge iclk);
    #1;
    irst = 1'b0;
    repeat (2) @(posedge iclk);

    // basic frame, ramp payload, latency from isop to first preamble symbol
    rdy_mode = 0;
    gen_ramp(16);
    expect_frame(16, MAX_A);
    start_cyc = -1;
    sop_cyc   = -1;
    e0 = err_pulses;
    send_pkt(16, 1'b0, -1);
    idle_in();
    drain_compare("basic");
    check("latency", 32'(sop_cyc - start_cyc), 32'd2);
    check("basic_err", 32'(err_pulses - e0), 32'd0);

    // same packet under alternating backpressure
    rdy_mode = 1;
    gen_ramp(16);
    expect_frame(16, MAX_A);
    send_pkt(16, 1'b0, -1);
    idle_in();
    drain_compare("bp");
    rdy_mode = 0;

    // back-to-back random packets, bubbles, random ready, stray mid-packet sop
    rdy_mode = 2;
    e0 = err_pulses;
    for (int p = 0; p < 3; p++) begin
      n = (p == 0) ? 1 : $urandom_range(2, 40);
      gen_rand(n);
      expect_frame(n, MAX_A);
      send_pkt(n, 1'b1, (p == 1) ? 1 : -1);
    end
    idle_in();
    drain_compare("b2b");
    check("b2b_err", 32'(err_pulses - e0), 32'd0);
    rdy_mode = 0;
    repeat (4) @(posedge iclk);

    // orphan symbol in idle
    e0 = err_pulses;
    @(posedge iclk);
    #1;
    ival = 1'b1;
    isop = 1'b0;
    ieop = 1'b0;
    idat = 5'd3;
    @(negedge iclk);
    check("orphan_ordy", 32'(o_ordy), 32'd1);
    check("orphan_oval", 32'(o_oval), 32'd0);
    @(posedge iclk);
    #1;
    ival = 1'b0;
    @(negedge iclk);
    check("orphan_oerr", 32'(o_oerr), 32'd1);
    check("orphan_ordy_off", 32'(o_ordy), 32'd0);
    check("orphan_oval2", 32'(o_oval), 32'd0);
    @(negedge iclk);
    check("orphan_oerr_off", 32'(o_oerr), 32'd0);
    check("orphan_count", 32'(err_pulses - e0), 32'd1);

    // overlength on the short-limit instance
    @(posedge iclk);
    #1;
    sel = 1'b1;
    rdy_mode = 2;
    e0 = err_pulses;
    gen_rand(12);
    expect_frame(12, MAX_B);
    send_pkt(12, 1'b1, -1);
    idle_in();
    drain_compare("over");
    check("over_err", 32'(err_pulses - e0), 32'd1);

    // payload exactly at the limit: no error, no drop
    e0 = err_pulses;
    gen_rand(MAX_B);
    expect_frame(MAX_B, MAX_B);
    send_pkt(MAX_B, 1'b1, -1);
    idle_in();
    drain_compare("exact");
    check("exact_err", 32'(err_pulses - e0), 32'd0);
    rdy_mode = 0;
    repeat (4) @(posedge iclk);
    #1;
    sel = 1'b0;

    // reset during the preamble, then a fresh frame
    act_q.delete();
    exp_q.delete();
    @(posedge iclk);
    #1;
    ival = 1'b1;
    isop = 1'b1;
    ieop = 1'b0;
    idat = 5'd7;
    guard = 0;
    while (act_q.size() < 50 && guard < 1000) begin
      @(negedge iclk);
      guard++;
    end
    check("pre50_reached", 32'(act_q.size() >= 50), 32'd1);
    @(posedge iclk);
    #1;
    irst = 1'b1;
    @(posedge iclk);
    #1;
    ival = 1'b0;
    isop = 1'b0;
    @(negedge iclk);
    check("mrst_oval", 32'(o_oval), 32'd0);
    check("mrst_osop", 32'(o_osop), 32'd0);
    check("mrst_oeop", 32'(o_oeop), 32'd0);
    check("mrst_odat", 32'(o_odat), 32'd0);
    check("mrst_oerr", 32'(o_oerr), 32'd0);
    check("mrst_ordy", 32'(o_ordy), 32'd0);
    @(posedge iclk);
    #1;
    irst = 1'b0;
    act_q.delete();
    exp_q.delete();
    rdy_mode = 2;
    gen_rand(20);
    expect_frame(20, MAX_A);
    send_pkt(20, 1'b1, -1);
    idle_in();
    drain_compare("post_rst");

    repeat (5) @(posedge iclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
